// File: rtl/nixie_pkg.sv
// Shared types and the 7-segment decode table
// for the BCD scan counter.
package nixie_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] bcd_to_seg(
    input bcd_t d
  );
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control/data bundle between the counter
// and whoever drives it.
interface bcd_scan_counter_if #(
  parameter int DIGITS = 4
);

  logic                  en;
  logic                  up_down;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   value;
  logic                  wrap;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     sel;

  modport master (
    output en,
    output up_down,
    output clr,
    output load,
    output load_val,
    input  value,
    input  wrap,
    input  seg,
    input  sel
  );

  modport slave (
    input  en,
    input  up_down,
    input  clr,
    input  load,
    input  load_val,
    output value,
    output wrap,
    output seg,
    output sel
  );

endinterface

// File: rtl/tick_div.sv
// Free-running divider: one-cycle pulse
// every DIV clocks.
module tick_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pulse
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign pulse = (cnt == LAST);

  // count 0..DIV-1 and fold back on the pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (pulse) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a
// multiplexed active-low 7-segment driver.
module bcd_scan_counter
  import nixie_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int LZB      = 0
) (
  input  logic clk,
  input  logic rst,
  bcd_scan_counter_if.slave bus
);

  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(DIGITS - 1);

  logic                   tick;
  logic                   step;
  logic                   go;
  logic [DIGITS:0]        cy;
  logic [DIGITS-1:0][3:0] dig;
  logic [DIGITS-1:0]      blank;
  logic [SW-1:0]          idx;
  logic                   wrap_q;
  logic [7:0]             seg_q;
  logic [DIGITS-1:0]      sel_q;

  tick_div #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .pulse (tick)
  );

  tick_div #(.DIV(SCAN_DIV)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .pulse (step)
  );

  // clr/load swallow a coincident tick
  assign go    = tick & bus.en & ~bus.clr & ~bus.load;
  assign cy[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic lim;
    bcd_t d;
    bcd_t ld;
    bcd_t nxt;

    assign lim = bus.up_down ? (d == 4'd9)
                             : (d == 4'd0);
    assign cy[i+1] = cy[i] & lim;

    assign ld = (bus.load_val[4*i +: 4] > 4'd9)
              ? 4'd0
              : bus.load_val[4*i +: 4];

    assign nxt = lim
               ? (bus.up_down ? 4'd0 : 4'd9)
               : (bus.up_down ? d + 4'd1 : d - 4'd1);

    // digit register: clear, load, then ripple step
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d <= 4'd0;
      end else if (bus.clr) begin
        d <= 4'd0;
      end else if (bus.load) begin
        d <= ld;
      end else if (go & cy[i]) begin
        d <= nxt;
      end
    end

    assign dig[i] = d;
    assign bus.value[4*i +: 4] = d;

    if (i == 0) begin : g_b0
      assign blank[i] = 1'b0;
    end else begin : g_bn
      assign blank[i] = (LZB != 0) &&
                        (dig[DIGITS-1:i] == '0);
    end
  end

  // wrap flags the cycle the rolled-over value shows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= go & cy[DIGITS];
    end
  end

  // scan position advances on each step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (step) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  // registered drive of the shared segment bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      sel_q <= '1;
    end else begin
      seg_q <= blank[idx] ? SEG_BLANK
                          : bcd_to_seg(dig[idx]);
      sel_q <= ~(DIGITS'(1) << idx);
    end
  end

  assign bus.wrap = wrap_q;
  assign bus.seg  = seg_q;
  assign bus.sel  = sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Randomised bench for bcd_scan_counter with
// an integer-arithmetic reference model.
module tb_bcd_scan_counter;

  localparam int D    = 2;
  localparam int TD   = 4;
  localparam int SD   = 2;
  localparam int MAXV = 99;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] lval = 8'h00;

  bcd_scan_counter_if #(.DIGITS(D)) b0 ();
  bcd_scan_counter_if #(.DIGITS(D)) b1 ();

  assign b0.en       = en;
  assign b0.up_down  = up;
  assign b0.clr      = clr;
  assign b0.load     = load;
  assign b0.load_val = lval;
  assign b1.en       = en;
  assign b1.up_down  = up;
  assign b1.clr      = clr;
  assign b1.load     = load;
  assign b1.load_val = lval;

  bcd_scan_counter #(
    .DIGITS(D), .TICK_DIV(TD),
    .SCAN_DIV(SD), .LZB(0)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  bcd_scan_counter #(
    .DIGITS(D), .TICK_DIV(TD),
    .SCAN_DIV(SD), .LZB(1)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h",
               nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] segtab [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  int         mval;
  int         tph;
  int         sph;
  int         sidx;
  int         tick_cnt = 0;
  bit         mwrap;
  bit         mtk;
  bit         mst;
  logic [1:0] msel;
  logic [7:0] mseg0;
  logic [7:0] mseg1;

  function automatic logic [7:0] seg_of(
    input int v, input int k, input bit lzb
  );
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    if (lzb && k > 0 && v < p) return 8'hFF;
    return segtab[(v / p) % 10];
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [7:0] lv);
    int hi;
    int lo;
    hi = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
    lo = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
    return hi * 10 + lo;
  endfunction

  // model advances one clock from the rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mval  = 0;
      tph   = 0;
      sph   = 0;
      sidx  = 0;
      mwrap = 1'b0;
      msel  = 2'b11;
      mseg0 = 8'hFF;
      mseg1 = 8'hFF;
    end else begin
      mtk = (tph == TD - 1);
      mst = (sph == SD - 1);
      tph = (tph + 1) % TD;
      sph = (sph + 1) % SD;
      if (mtk) tick_cnt++;
      msel = 2'b11;
      msel[sidx] = 1'b0;
      mseg0 = seg_of(mval, sidx, 1'b0);
      mseg1 = seg_of(mval, sidx, 1'b1);
      mwrap = 1'b0;
      if (clr) begin
        mval = 0;
      end else if (load) begin
        mval = from_load(lval);
      end else if (mtk && en) begin
        if (up) begin
          if (mval == MAXV) begin
            mval = 0;
            mwrap = 1'b1;
          end else begin
            mval++;
          end
        end else begin
          if (mval == 0) begin
            mval = MAXV;
            mwrap = 1'b1;
          end else begin
            mval--;
          end
        end
      end
      if (mst) sidx = (sidx + 1) % D;
    end
  end

  // per-cycle comparison against the model
  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_value0", b0.value, to_bcd(mval));
      chk("m_value1", b1.value, to_bcd(mval));
      chk("m_wrap0", b0.wrap, mwrap);
      chk("m_wrap1", b1.wrap, mwrap);
      chk("m_sel0", b0.sel, msel);
      chk("m_sel1", b1.sel, msel);
      chk("m_seg0", b0.seg, mseg0);
      chk("m_seg1", b1.seg, mseg1);
    end
  end

  task automatic wait_ticks(input int n);
    int tgt;
    int b;
    tgt = tick_cnt + n;
    b = 0;
    while (tick_cnt < tgt && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (tick_cnt < tgt) begin
      fails++;
      $display("FAIL tick_wait: got %0d, want %0d",
               tick_cnt, tgt);
    end
  endtask

  logic [1:0] hist [8];

  initial begin
    @(negedge clk);
    chk("rst_value", b0.value, 8'h00);
    chk("rst_wrap", b0.wrap, 1'b0);
    chk("rst_seg0", b0.seg, 8'hFF);
    chk("rst_seg1", b1.seg, 8'hFF);
    chk("rst_sel", b0.sel, 2'b11);
    cmp_on = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_sel", b0.sel, 2'b10);

    // reset in the middle of counting
    load = 1'b1;
    lval = 8'h37;
    @(negedge clk);
    load = 1'b0;
    en = 1'b1;
    up = 1'b1;
    wait_ticks(3);
    chk("t1_count", b0.value, 8'h40);
    #2 rst = 1'b1;
    #1;
    chk("t1_value", b0.value, 8'h00);
    chk("t1_seg0", b0.seg, 8'hFF);
    chk("t1_seg1", b1.seg, 8'hFF);
    chk("t1_sel", b0.sel, 2'b11);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_sel_rel", b0.sel, 2'b10);

    // up wrap
    load = 1'b1;
    lval = 8'h98;
    @(negedge clk);
    load = 1'b0;
    wait_ticks(1);
    chk("t2_99", b0.value, 8'h99);
    chk("t2_nowrap", b0.wrap, 1'b0);
    wait_ticks(1);
    chk("t2_00", b0.value, 8'h00);
    chk("t2_wrap", b0.wrap, 1'b1);
    @(negedge clk);
    chk("t2_wrap_off", b0.wrap, 1'b0);

    // down wrap
    up = 1'b0;
    wait_ticks(1);
    chk("t3_99", b0.value, 8'h99);
    chk("t3_wrap", b0.wrap, 1'b1);
    wait_ticks(1);
    chk("t3_98", b0.value, 8'h98);
    chk("t3_nowrap", b0.wrap, 1'b0);

    // invalid nibble loads as zero
    en = 1'b0;
    load = 1'b1;
    lval = 8'h5A;
    @(negedge clk);
    load = 1'b0;
    chk("t4_value", b0.value, 8'h50);
    chk("t4_wrap", b0.wrap, 1'b0);

    // clr beats load beats tick
    en = 1'b1;
    up = 1'b1;
    for (int k = 0; k < 10 && tph != TD - 1; k++)
      @(negedge clk);
    chk("t5_phase", tph, TD - 1);
    clr = 1'b1;
    load = 1'b1;
    lval = 8'h42;
    @(negedge clk);
    clr = 1'b0;
    load = 1'b0;
    chk("t5_value", b0.value, 8'h00);
    chk("t5_wrap", b0.wrap, 1'b0);
    wait_ticks(1);
    chk("t5_next", b0.value, 8'h01);

    // scan with and without blanking
    en = 1'b0;
    load = 1'b1;
    lval = 8'h07;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      hist[k] = b0.sel;
      if (msel == 2'b10) begin
        chk("t6_seg_u1", b1.seg, 8'hF8);
        chk("t6_seg_u0", b0.seg, 8'hF8);
      end else begin
        chk("t6_seg_t1", b1.seg, 8'hFF);
        chk("t6_seg_t0", b0.seg, 8'hC0);
      end
      if (k >= 2)
        chk("t6_alt", hist[k] ^ hist[k-2], 2'b11);
    end

    // random traffic, one reset mid-run
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 200) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      en   = ($urandom % 4) != 0;
      clr  = ($urandom % 25) == 0;
      load = ($urandom % 12) == 0;
      lval = 8'($urandom);
      if (($urandom % 30) == 0) up = ~up;
    end
    clr = 1'b0;
    load = 1'b0;
    @(negedge clk);
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

endmodule
